// File: rtl/hamming74_uart_tx.sv
// Hamming(7,4) encoder with single-bit error injection, serialised as a UART frame on tx.
// Optional even parity bit before stop is compiled in with `define HAMMING_TX_PARITY_EN.
module hamming74_uart_tx #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  input  logic [2:0] inject_pos,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [6:0] code_out,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

  state_t     state, state_nxt;
  logic [7:0] baud_cnt, baud_nxt;
  logic [2:0] bit_idx, bit_nxt;
  logic [6:0] code_nxt;
  logic [6:0] inj_mask;
  logic       tx_nxt;
  logic       accept;
  logic       bit_end;

  // Codeword bit k-1 holds Hamming position k: {d3,d2,d1,p4,d0,p2,p1}.
  function automatic logic [6:0] hamming_encode(input logic [3:0] d);
    return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= 8'd0;
      bit_idx  <= 3'd0;
      code_out <= 7'd0;
      tx       <= 1'b1;
    end else if (ena) begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      code_out <= code_nxt;
      tx       <= tx_nxt;
    end
  end

  assign accept   = ready && data_valid;
  assign bit_end  = (baud_cnt == LAST_CNT);
  assign inj_mask = (inject_pos == 3'd0) ? 7'd0 : (7'd1 << (inject_pos - 3'd1));

  always_comb begin
    state_nxt = state;
    baud_nxt  = bit_end ? 8'd0 : baud_cnt + 8'd1;
    bit_nxt   = bit_idx;
    code_nxt  = code_out;
    case (state)
      IDLE: begin
        baud_nxt = 8'd0;
        bit_nxt  = 3'd0;
        if (accept) begin
          state_nxt = START;
          code_nxt  = hamming_encode(data_in) ^ inj_mask;
        end
      end
      START: begin
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd6) begin
            bit_nxt = 3'd0;
`ifdef HAMMING_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bit_nxt = bit_idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        if (bit_end) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        baud_nxt  = 8'd0;
        bit_nxt   = 3'd0;
      end
    endcase
  end

  // tx is registered from the next state so the line changes exactly on bit boundaries.
  always_comb begin
    ready     = (state == IDLE) && ena;
    busy      = (state != IDLE);
    done      = (state == STOP) && bit_end && ena;
    state_out = state;
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = code_nxt[bit_nxt];
      PARITY:  tx_nxt = ^code_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_hamming74_uart_tx.sv
// Self-checking bench for hamming74_uart_tx: a frame-level reference model checked every cycle,
// plus directed literal checks of codewords, bit sequence, done latency and handshake spacing.
module tb_hamming74_uart_tx;

  localparam int CPB = 8;
`ifdef HAMMING_TX_PARITY_EN
  localparam int NBITS = 10;
  localparam bit PAR = 1'b1;
`else
  localparam int NBITS = 9;
  localparam bit PAR = 1'b0;
`endif
  localparam int TOTAL = NBITS * CPB;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [3:0] data_in;
  logic       data_valid;
  logic [2:0] inject_pos;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       done;
  logic [6:0] code_out;
  logic [2:0] state_out;

  hamming74_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .data_in    (data_in),
    .data_valid (data_valid),
    .inject_pos (inject_pos),
    .ready      (ready),
    .tx         (tx),
    .busy       (busy),
    .done       (done),
    .code_out   (code_out),
    .state_out  (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: frame progress counted in enabled cycles since accept.
  bit         m_valid    = 1'b0;
  bit         m_busy     = 1'b0;
  logic [6:0] m_code;
  int         m_n        = 0;
  int         m_accepts  = 0;
  int         m_acc_cyc  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp = n_cmp + 1;
    if (actual !== expected) begin
      n_fail = n_fail + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Classic Hamming construction: data fills non-power-of-two positions, parity p covers positions j with (j & p) != 0.
  function automatic logic [6:0] ref_encode(input logic [3:0] d, input logic [2:0] inj);
    logic [7:1] pos;
    int         data_pos [4];
    logic       par;
    data_pos = '{3, 5, 6, 7};
    pos = '0;
    for (int i = 0; i < 4; i++) pos[data_pos[i]] = d[i];
    for (int p = 1; p <= 4; p = p * 2) begin
      par = 1'b0;
      for (int j = 3; j <= 7; j++) if ((j & p) != 0) par = par ^ pos[j];
      pos[p] = par;
    end
    if (inj != 3'd0) pos[inj] = ~pos[inj];
    return pos[7:1];
  endfunction

  function automatic logic ref_frame_bit(input logic [6:0] code, input int j);
    if (j == 0) return 1'b0;
    if (j <= 7) return code[j-1];
    if (PAR && j == 8) return ^code;
    return 1'b1;
  endfunction

  function automatic logic [2:0] ref_state(input int j);
    if (j == 0) return 3'd1;
    if (j <= 7) return 3'd2;
    if (PAR && j == 8) return 3'd3;
    return 3'd4;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_valid <= 1'b1;
      m_busy  <= 1'b0;
      m_code  <= 7'd0;
      m_n     <= 0;
    end else if (m_valid && ena) begin
      if (!m_busy) begin
        if (data_valid) begin
          m_busy    <= 1'b1;
          m_code    <= ref_encode(data_in, inject_pos);
          m_n       <= 0;
          m_accepts <= m_accepts + 1;
          m_acc_cyc <= cyc + 1;
        end
      end else if (m_n == TOTAL - 1) begin
        m_busy <= 1'b0;
      end else begin
        m_n <= m_n + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      if (m_busy) begin
        checkOutput("tx", tx, ref_frame_bit(m_code, m_n / CPB));
        checkOutput("state_out", state_out, ref_state(m_n / CPB));
        checkOutput("done", done, (ena && m_n == TOTAL - 1));
      end else begin
        checkOutput("tx_idle", tx, 1'b1);
        checkOutput("state_idle", state_out, 3'd0);
        checkOutput("done_idle", done, 1'b0);
      end
      checkOutput("busy", busy, m_busy);
      checkOutput("ready", ready, (!m_busy && ena));
      checkOutput("code_out", code_out, m_code);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Presents a nibble and holds data_valid until the model sees it accepted.
  task automatic applyStimulus(input logic [3:0] d, input logic [2:0] inj);
    int start;
    start      = m_accepts;
    data_in    = d;
    inject_pos = inj;
    data_valid = 1'b1;
    for (int k = 0; k < 2000 && m_accepts == start; k++) tick();
    if (m_accepts == start) checkOutput("accept_timeout", 0, 1);
    data_valid = 1'b0;
    data_in    = 4'($urandom);
    inject_pos = 3'($urandom);
  endtask

  task automatic waitDone(output int lat);
    lat = -1;
    for (int k = 0; k < 4 * TOTAL; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = cyc - m_acc_cyc;
        break;
      end
    end
    if (lat < 0) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic checkFrameBits(input logic [9:0] exp_bits);
    for (int b = 0; b < NBITS; b++) begin
      for (int k = 0; k < TOTAL && (cyc - m_acc_cyc) < b * CPB + CPB / 2; k++) @(negedge clk);
      checkOutput($sformatf("frame_bit%0d", b), tx, exp_bits[b]);
    end
  endtask

  task automatic sendAndCheck(input string name, input logic [3:0] d, input logic [2:0] inj, input logic [6:0] exp_code);
    int lat;
    applyStimulus(d, inj);
    @(negedge clk);
    checkOutput({name, "_code"}, code_out, exp_code);
    waitDone(lat);
    checkOutput({name, "_latency"}, lat, TOTAL - 1);
  endtask

  initial begin
    int lat;
    int prev_acc;
    int seen;
    logic [9:0] exp_bits;

    rst_n      = 1'b0;
    ena        = 1'b1;
    data_in    = 4'd0;
    data_valid = 1'b0;
    inject_pos = 3'd0;

    checkOutput("model_enc_1011", ref_encode(4'b1011, 3'd0), 7'h55);
    checkOutput("model_enc_F", ref_encode(4'hF, 3'd0), 7'h7F);
    checkOutput("model_inj3", ref_encode(4'b1011, 3'd3), 7'h51);

    repeat (3) tick();
    @(negedge clk);
    checkOutput("rst_tx", tx, 1'b1);
    checkOutput("rst_ready", ready, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_state", state_out, 3'd0);
    checkOutput("rst_code", code_out, 7'd0);
    tick();
    rst_n = 1'b1;
    tick();

    applyStimulus(4'b1011, 3'd0);
    @(negedge clk);
    checkOutput("enc_code", code_out, 7'h55);
    exp_bits = PAR ? 10'h2AA : 10'h1AA;
    checkFrameBits(exp_bits);
    waitDone(lat);
    checkOutput("enc_latency", lat, TOTAL - 1);

    sendAndCheck("zero", 4'h0, 3'd0, 7'h00);
    sendAndCheck("ones", 4'hF, 3'd0, 7'h7F);
    sendAndCheck("inj3", 4'b1011, 3'd3, 7'h51);
    sendAndCheck("inj7", 4'b1011, 3'd7, 7'h15);

    // Continuous data_valid: frames must be spaced by exactly one idle cycle.
    data_valid = 1'b1;
    prev_acc   = -1;
    seen       = m_accepts;
    for (int k = 0; k < 5 * (TOTAL + 1) && m_accepts < seen + 3; k++) begin
      data_in    = 4'($urandom);
      inject_pos = 3'($urandom);
      tick();
      if (m_accepts != seen + (prev_acc < 0 ? 0 : 1) && prev_acc >= 0) begin
        checkOutput("b2b_spacing", m_acc_cyc - prev_acc, TOTAL + 1);
        prev_acc = m_acc_cyc;
        seen     = seen + 1;
      end else if (prev_acc < 0 && m_accepts != seen) begin
        prev_acc = m_acc_cyc;
      end
    end
    if (m_accepts < 3) checkOutput("b2b_timeout", m_accepts, 3);
    data_valid = 1'b0;
    waitDone(lat);
    tick();

    applyStimulus(4'h9, 3'd0);
    repeat (20) tick();
    @(negedge clk);
    checkOutput("ena_in_data", state_out, 3'd2);
    tick();
    ena = 1'b0;
    repeat (5) tick();
    ena = 1'b1;
    waitDone(lat);
    checkOutput("ena_stretch", lat, TOTAL - 1 + 5);

    applyStimulus(4'h3, 3'd0);
    repeat (30) tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("midrst_tx", tx, 1'b1);
    checkOutput("midrst_state", state_out, 3'd0);
    checkOutput("midrst_done", done, 1'b0);
    tick();
    rst_n = 1'b1;
    sendAndCheck("after_rst", 4'h6, 3'd5, ref_encode(4'h6, 3'd5));

    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      ena = 1'b1;
      applyStimulus(4'($urandom), 3'($urandom));
      for (int k = 0; k < 4 * TOTAL && m_busy; k++) begin
        ena = ($urandom_range(0, 7) != 0);
        tick();
      end
      ena = 1'b1;
      if (m_busy) checkOutput("rand_timeout", 0, 1);
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/hamming74_uart_tx.md
# hamming74_uart_tx

Upstream transmit stage of the Hamming(7,4) UART link. It accepts a 4-bit nibble through a valid/ready handshake and encodes it into a 7-bit Hamming(7,4) codeword. It can optionally corrupt one chosen codeword bit, then serialises the codeword as a UART frame on `tx`. The frame is exactly what the on-chip UART receiver and Hamming(7,4) decoder consume, so the block serves as both the link's transmitter and its loopback/error-injection source.

## Interface
- `CLKS_PER_BIT`, default 8: clock cycles per UART bit period; legal range 2..255.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on `clk` rising edge.
- `ena`  in  1  design enable; low freezes all state.
- `data_in`  in  4  nibble `{d3,d2,d1,d0}` to transmit.
- `data_valid`  in  1  `data_in` is valid.
- `inject_pos`  in  3  error injection: 0 = none, 1..7 = flip codeword position N (bit index N-1); sampled with `data_in`.
- `ready`  out  1  block can accept a nibble.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse at end of stop bit.
- `code_out`  out  7  codeword latched for the current/last frame (post-injection).
- `state_out`  out  3  FSM state, for debug.

## Operation
- Encoding, position k = bit index k-1:
  - pos1 = p1 = d0^d1^d3
  - pos2 = p2 = d0^d2^d3
  - pos3 = d0
  - pos4 = p4 = d1^d2^d3
  - pos5 = d1
  - pos6 = d2
  - pos7 = d3
- Injection: `code_out` = encoded codeword XOR (`inject_pos`≠0 ? 1<<(`inject_pos`-1) : 0).
- Accept: on an edge where `ready` && `data_valid` are both high, the block latches `code_out` and enters START.
- Frame, in order: start bit (0), then `code_out[0]`..`code_out[6]` (LSB first), then the optional parity bit (see Configuration), then stop bit (1).
- FSM `state_out` encoding:
  - IDLE=0: `tx`=1. Goes to START on accept.
  - START=1: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
  - DATA=2: 7 bit periods, using a 3-bit bit index 0..6. After index 6 completes, goes to PARITY if parity is compiled in, else STOP.
  - PARITY=3: one bit period, then STOP.
  - STOP=4: `tx`=1 for one bit period. In the last cycle `done` is asserted; the next state is IDLE.
  - Codes 5..7 are illegal and return to IDLE on the next enabled edge.
- `ready` = (state==IDLE) && `ena`, combinational. `busy` = (state≠IDLE).
- Baud counter counts 0..`CLKS_PER_BIT`-1 and wraps at each bit boundary. It is cleared on accept.
- `ena` low:
  - FSM, baud counter and bit index hold.
  - `tx` holds its level; `done` is forced 0.
  - `ready`=0, so no accept is possible.
- `data_valid` while busy is ignored. There is no buffering; the upstream holds its data until `ready`.
- `tx` is registered and glitch-free.

## Timing
- Reset (`rst_n` low at an edge): state=IDLE, `tx`=1, `done`=0, `code_out`=0, baud counter=0, bit index=0. `ready` is 1 after reset if `ena`=1.
- Reset mid-frame aborts the frame; `tx` is 1 the cycle after the reset edge.
- Accept at edge E: `tx`=0 from E, so the start bit occupies cycles E..E+`CLKS_PER_BIT`-1.
- Frame length: 9·`CLKS_PER_BIT` cycles, or 10·`CLKS_PER_BIT` with parity.
- `done` is high during the last cycle of the stop bit. IDLE and `ready`=1 follow on the next cycle, so back-to-back frames have 1 idle-high cycle between stop and next start.
- `code_out` is stable from E until the next accept.

## Configuration
- `HAMMING_TX_PARITY_EN` defined: the PARITY state is used. The bit is even parity over `code_out[6:0]`, i.e. XOR of the 7 bits. Frame = 10 bit periods.
- `HAMMING_TX_PARITY_EN` undefined: PARITY is never entered. Frame = 9 bit periods, matching the 7-data-bit receiver.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, `ena`=1 → `tx`=1, `ready`=1, `busy`=0, `state_out`=0, `code_out`=0.
- Encode: `data_in`=4'b1011, `inject_pos`=0, `CLKS_PER_BIT`=8 → `code_out`=7'h55. `tx` bits, each 8 cycles: 0,1,0,1,0,1,0,1,1. `done` pulses at cycle 71 after accept. With the macro, parity bit 0 precedes stop.
- Corner codes: `data_in`=0 → `code_out`=7'h00. `data_in`=4'hF → `code_out`=7'h7F; with the macro, parity=1.
- Injection: `data_in`=4'b1011, `inject_pos`=3 → `code_out`=7'h51, transmitted LSB first. `inject_pos`=7 → 7'h15.
- Handshake and `ena`: hold `data_valid` high continuously → frames back-to-back with exactly 1 idle cycle; a second `data_valid` mid-frame is ignored. Drop `ena` for 5 cycles in DATA → frame stretched by 5 cycles, bit values unchanged.
- Reset mid-frame: `rst_n`=0 during DATA → next cycle `tx`=1, `state_out`=0, no `done`. A new nibble is then transmitted correctly.
